ahb_decoder_mux: RTL

- Single-master AHB-Lite address decoder and response multiplexer. Sits between the CPU master port and the AHB slaves, including the on-chip SRAM slave.
- Generates per-slave select from the address-phase address. Registers the data-phase owner and muxes hrdata/hreadyout/hresp back to the master.
- Contains a built-in default slave: two-cycle ERROR on unmapped addresses, decode-error counter, and a hung-slave watchdog flag.

---
 rtl/ahb_decoder_mux.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite single-master address decoder and response mux.
// Built-in default slave answers unmapped transfers with a two-cycle ERROR.
module ahb_decoder_mux #(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_LSB     = 28,
  parameter int SEL_WIDTH   = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [HADDR_WIDTH-1:0]           haddr,
  input  logic [1:0]                       htrans,
  output logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             hready,
  output logic                             hresp,
  output logic [NUM_SLAVES-1:0]            s_hsel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
  input  logic [NUM_SLAVES-1:0]            s_hreadyout,
  input  logic [NUM_SLAVES-1:0]            s_hresp,
  output logic [7:0]                       dec_err_cnt,
  output logic                             timeout_flag,
  input  logic                             timeout_clr
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ERR1,
    ERR2
  } ds_state_t;

  ds_state_t             state;
  logic                  ds_ready;
  logic                  ds_resp;
  logic [SEL_WIDTH-1:0]  idx;
  logic [NUM_SLAVES:0]   dec;
  logic [NUM_SLAVES:0]   dp_sel;
  logic                  err_go;
  logic                  slv_ready;
  logic                  slv_resp;
  logic [DATA_WIDTH-1:0] slv_data;
  logic [WW-1:0]         wait_cnt;
  logic                  wd_set;
  logic                  unused_ok;

  assign idx = haddr[SEL_LSB +: SEL_WIDTH];

  // Top entry of dec is the default slave: taken when no slave matches.
  always_comb begin
    dec = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      dec[k] = (idx == SEL_WIDTH'(k));
    end
    dec[NUM_SLAVES] = ~|dec[NUM_SLAVES-1:0];
  end

  assign s_hsel = dec[NUM_SLAVES-1:0];

  always_comb begin
    slv_ready = 1'b0;
    slv_resp  = 1'b0;
    slv_data  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (dp_sel[k]) begin
        slv_ready = s_hreadyout[k];
        slv_resp  = s_hresp[k];
        slv_data  = s_hrdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hready = dp_sel[NUM_SLAVES] ? ds_ready : slv_ready;
  assign hresp  = dp_sel[NUM_SLAVES] ? ds_resp  : slv_resp;
  assign hrdata = dp_sel[NUM_SLAVES] ? '0       : slv_data;

  assign err_go = hready & dec[NUM_SLAVES] & htrans[1];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_sel <= (NUM_SLAVES+1)'(1) << NUM_SLAVES;
    end else if (hready) begin
      dp_sel <= dec;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= IDLE;
      ds_ready <= 1'b1;
      ds_resp  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ERR2: begin
          if (err_go) begin
            state    <= ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end else begin
            state    <= IDLE;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
          end
        end
        ERR1: begin
          state    <= ERR2;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dec_err_cnt <= '0;
    end else if (timeout_clr) begin
      dec_err_cnt <= '0;
    end else if (err_go && dec_err_cnt != 8'hFF) begin
      dec_err_cnt <= dec_err_cnt + 8'd1;
    end
  end

  // Flag rises on the edge that completes the TIMEOUT_CYC-th wait cycle.
  assign wd_set = !hready && (wait_cnt >= WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (hready) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WW'(TIMEOUT_CYC)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
      if (wd_set) begin
        timeout_flag <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag <= 1'b0;
      end
    end
  end

  assign unused_ok = ^{haddr, htrans[0]};

endmodule
